// File: rtl/irq_pkg.sv
// irq_pkg: shared widths and index decode for the request-capture and encoder blocks
package irq_pkg;
    localparam int IRQ_WIDTH = 8;
    localparam int IRQ_IDX_W = 3;

    function automatic logic [IRQ_WIDTH-1:0] idx_to_onehot(input logic [IRQ_IDX_W-1:0] idx);
        return IRQ_WIDTH'(1) << idx;
    endfunction
endpackage

// File: rtl/irq_pending_latch_sync_edge_det.sv
// sync_edge_det: two-flop synchroniser plus history flop, one rising-edge pulse per line
module sync_edge_det #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] rise
);
    logic [W-1:0] s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
endmodule

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: latches masked request edges into a sticky pending vector cleared by indexed acks
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int WIDTH = IRQ_WIDTH,
    parameter int IDX_W = IRQ_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] mask,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] pending,
    output logic             pend_valid,
    output logic [WIDTH-1:0] overrun,
    output logic             ack_err
);
    logic [WIDTH-1:0] rise, set, clr;

    sync_edge_det #(.W(WIDTH)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (req),
        .rise (rise)
    );

    // an out-of-range index decodes to zero, so it clears nothing and reads as not pending
    assign clr        = ack ? WIDTH'(idx_to_onehot(IRQ_IDX_W'(ack_idx))) : '0;
    assign set        = rise & mask;
    assign pend_valid = |pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= '0;
            ack_err <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | set;
            overrun <= (overrun & ~{WIDTH{clr_overrun}}) | (set & pending & ~clr);
            ack_err <= ack & ~|(pending & clr);
        end
    end
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed vectors with hand-computed expectations
module tb_irq_pending_latch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] mask = '0;
    logic       ack = 1'b0;
    logic [2:0] ack_idx = '0;
    logic       clr_overrun = 1'b0;
    logic [7:0] pending, overrun;
    logic       pend_valid, ack_err;
    int         total = 0;
    int         bad = 0;

    irq_pending_latch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mask       (mask),
        .ack        (ack),
        .ack_idx    (ack_idx),
        .clr_overrun(clr_overrun),
        .pending    (pending),
        .pend_valid (pend_valid),
        .overrun    (overrun),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ack(input logic [2:0] idx);
        ack = 1'b1;
        ack_idx = idx;
        tick(1);
        ack = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_pend", pending, 8'h00);
        chk("rst_ovr", overrun, 8'h00);
        chk("rst_err", {7'd0, ack_err}, 8'h00);
        chk("rst_valid", {7'd0, pend_valid}, 8'h00);
        rst_n = 1'b1;

        mask = 8'hFF;
        req = 8'h28;
        tick(2);
        chk("lat_early", pending, 8'h00);
        tick(1);
        chk("lat_pend", pending, 8'h28);
        chk("lat_valid", {7'd0, pend_valid}, 8'h01);
        chk("lat_ovr", overrun, 8'h00);
        req = 8'h00;
        tick(3);
        chk("lat_hold", pending, 8'h28);

        do_ack(3'd5);
        chk("ack5", pending, 8'h08);
        chk("ack5_err", {7'd0, ack_err}, 8'h00);
        do_ack(3'd3);
        chk("ack3", pending, 8'h00);
        chk("ack3_valid", {7'd0, pend_valid}, 8'h00);

        mask = 8'hF0;
        req = 8'h1F;
        tick(3);
        chk("mask_pend", pending, 8'h10);
        mask = 8'hFF;
        tick(3);
        chk("unmask_pend", pending, 8'h10);
        req = 8'h00;
        tick(3);
        do_ack(3'd4);
        chk("ack4", pending, 8'h00);

        req = 8'h02;
        tick(3);
        chk("ovr_first", pending, 8'h02);
        req = 8'h00;
        tick(2);
        req = 8'h02;
        tick(3);
        chk("ovr_set", overrun, 8'h02);
        chk("ovr_pend", pending, 8'h02);
        req = 8'h00;
        tick(2);
        req = 8'h02;
        tick(2);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        chk("ovr_clr_race", overrun, 8'h02);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        chk("ovr_clr", overrun, 8'h00);
        req = 8'h00;
        tick(3);
        do_ack(3'd1);
        chk("ack1", pending, 8'h00);

        req = 8'h04;
        tick(3);
        chk("sim_first", pending, 8'h04);
        req = 8'h00;
        tick(2);
        req = 8'h04;
        tick(2);
        do_ack(3'd2);
        chk("sim_pend", pending, 8'h04);
        chk("sim_ovr", overrun, 8'h00);
        chk("sim_err", {7'd0, ack_err}, 8'h00);

        do_ack(3'd6);
        chk("bad_err", {7'd0, ack_err}, 8'h01);
        chk("bad_pend", pending, 8'h04);
        tick(1);
        chk("bad_pulse", {7'd0, ack_err}, 8'h00);

        ack = 1'b1;
        ack_idx = 3'd2;
        tick(1);
        chk("b2b_pend", pending, 8'h00);
        chk("b2b_err0", {7'd0, ack_err}, 8'h00);
        tick(1);
        ack = 1'b0;
        chk("b2b_err1", {7'd0, ack_err}, 8'h01);
        req = 8'h00;
        tick(3);

        req = 8'h97;
        tick(3);
        req = 8'h00;
        tick(2);
        req = 8'h01;
        tick(3);
        do_ack(3'd0);
        chk("mid_pend", pending, 8'h96);
        chk("mid_ovr", overrun, 8'h01);
        req = 8'h80;
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_pend", pending, 8'h00);
        chk("mid_rst_ovr", overrun, 8'h00);
        chk("mid_rst_valid", {7'd0, pend_valid}, 8'h00);
        rst_n = 1'b1;
        tick(2);
        chk("rel_early", pending, 8'h00);
        tick(1);
        chk("rel_pend", pending, 8'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
